// File: rtl/bpred_tournament.sv
// ============================================================================
// Module   : bpred_tournament
// Brief    : Tournament branch direction predictor (local + gshare + chooser)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bpred_tournament #(
   parameter int LBITS  = 6,
   parameter int LHBITS = 6,
   parameter int GHBITS = 8,
   parameter int CBITS  = 2
) (
   input  logic              i_clk,
   input  logic              i_rst,
   output logic              o_ready,
   input  logic              i_pred_valid,
   input  logic [31:0]       i_pred_addr,
   output logic              o_pred_valid,
   output logic              o_pred_taken,
   output logic [GHBITS-1:0] o_pred_ghist,
   input  logic              i_update_en,
   input  logic [31:0]       i_update_addr,
   input  logic              i_update_taken,
   input  logic [GHBITS-1:0] i_update_ghist,
   input  logic              i_update_mispredict
);

   localparam int MAXB = (LBITS > LHBITS) ? ((LBITS > GHBITS) ? LBITS : GHBITS)
                                          : ((LHBITS > GHBITS) ? LHBITS : GHBITS);
   localparam int AMAX = (LBITS > GHBITS) ? LBITS : GHBITS;
   localparam int NL   = 1 << LBITS;
   localparam int NLP  = 1 << LHBITS;
   localparam int NG   = 1 << GHBITS;

   localparam logic [CBITS-1:0] c_ctr_one = CBITS'(1);
   localparam logic [CBITS-1:0] c_ctr_max = {CBITS{1'b1}};
   localparam logic [CBITS-1:0] c_ctr_wnt = CBITS'((1 << (CBITS - 1)) - 1);
   localparam logic [1:0]       c_cho_wl  = 2'b01;
   localparam logic [MAXB-1:0]  c_idx_one = MAXB'(1);

   typedef enum logic [0:0] {
      S_CLEAR = 1'b0,
      S_READY = 1'b1
   } state_t;

   state_t            r_state;
   logic [MAXB-1:0]   r_idx;
   logic [GHBITS-1:0] r_ghr;
   logic              r_ready;
   logic              r_pred_valid;
   logic              r_pred_taken;
   logic [GHBITS-1:0] r_pred_ghist;

   logic [LHBITS-1:0] r_lht  [NL];
   logic [1:0]        r_cho  [NL];
   logic [CBITS-1:0]  r_lpht [NLP];
   logic [CBITS-1:0]  r_gpht [NG];

   function automatic logic [CBITS-1:0] sat_ctr(input logic [CBITS-1:0] c, input logic up);
      if (up)
         return (c == c_ctr_max) ? c : c + c_ctr_one;
      else
         return (c == '0) ? c : c - c_ctr_one;
   endfunction

   // Update path: read-modify-write of every table touched by the resolved branch
   logic              w_upd;
   logic [LBITS-1:0]  w_u_lidx;
   logic [LHBITS-1:0] w_u_lh;
   logic [LHBITS-1:0] w_u_lh_new;
   logic [CBITS-1:0]  w_u_lctr;
   logic [CBITS-1:0]  w_u_lctr_new;
   logic [GHBITS-1:0] w_u_gidx;
   logic [CBITS-1:0]  w_u_gctr;
   logic [CBITS-1:0]  w_u_gctr_new;
   logic [1:0]        w_u_cho;
   logic [1:0]        w_u_cho_new;
   logic              w_u_local;
   logic              w_u_global;

   assign w_upd        = i_update_en & r_ready;
   assign w_u_lidx     = i_update_addr[LBITS+1:2];
   assign w_u_lh       = r_lht[w_u_lidx];
   assign w_u_lh_new   = {w_u_lh[LHBITS-2:0], i_update_taken};
   assign w_u_lctr     = r_lpht[w_u_lh];
   assign w_u_lctr_new = sat_ctr(w_u_lctr, i_update_taken);
   assign w_u_gidx     = i_update_ghist ^ i_update_addr[GHBITS+1:2];
   assign w_u_gctr     = r_gpht[w_u_gidx];
   assign w_u_gctr_new = sat_ctr(w_u_gctr, i_update_taken);
   assign w_u_cho      = r_cho[w_u_lidx];
   assign w_u_local    = w_u_lctr[CBITS-1];
   assign w_u_global   = w_u_gctr[CBITS-1];

   always_comb begin
      w_u_cho_new = w_u_cho;
      if (w_u_local != w_u_global) begin
         if (w_u_global == i_update_taken)
            w_u_cho_new = (w_u_cho == 2'b11) ? w_u_cho : w_u_cho + 2'b01;
         else
            w_u_cho_new = (w_u_cho == 2'b00) ? w_u_cho : w_u_cho - 2'b01;
      end
   end

   // Prediction path sees same-cycle update results through write-through forwarding
   logic [LBITS-1:0]  w_p_lidx;
   logic [LHBITS-1:0] w_p_lh;
   logic [CBITS-1:0]  w_p_lctr;
   logic [GHBITS-1:0] w_p_gidx;
   logic [CBITS-1:0]  w_p_gctr;
   logic [1:0]        w_p_cho;
   logic              w_p_taken;

   assign w_p_lidx  = i_pred_addr[LBITS+1:2];
   assign w_p_lh    = (w_upd && (w_u_lidx == w_p_lidx)) ? w_u_lh_new : r_lht[w_p_lidx];
   assign w_p_lctr  = (w_upd && (w_u_lh == w_p_lh)) ? w_u_lctr_new : r_lpht[w_p_lh];
   assign w_p_gidx  = r_ghr ^ i_pred_addr[GHBITS+1:2];
   assign w_p_gctr  = (w_upd && (w_u_gidx == w_p_gidx)) ? w_u_gctr_new : r_gpht[w_p_gidx];
   assign w_p_cho   = (w_upd && (w_u_lidx == w_p_lidx)) ? w_u_cho_new : r_cho[w_p_lidx];
   assign w_p_taken = w_p_cho[1] ? w_p_gctr[CBITS-1] : w_p_lctr[CBITS-1];

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= S_CLEAR;
         r_idx        <= '0;
         r_ghr        <= '0;
         r_ready      <= 1'b0;
         r_pred_valid <= 1'b0;
         r_pred_taken <= 1'b0;
         r_pred_ghist <= '0;
      end else begin
         case (r_state)
            S_CLEAR: begin
               r_pred_valid <= 1'b0;
               r_idx        <= r_idx + c_idx_one;
               if (r_idx == {MAXB{1'b1}}) begin
                  r_state <= S_READY;
                  r_ready <= 1'b1;
               end
            end
            S_READY: begin
               r_pred_valid <= i_pred_valid;
               if (i_pred_valid) begin
                  r_pred_taken <= w_p_taken;
                  r_pred_ghist <= r_ghr;
               end
               // A repair overrides the speculative shift of a same-cycle prediction
               if (w_upd && i_update_mispredict)
                  r_ghr <= {i_update_ghist[GHBITS-2:0], i_update_taken};
               else if (i_pred_valid)
                  r_ghr <= {r_ghr[GHBITS-2:0], w_p_taken};
            end
            default: begin
               r_state <= S_CLEAR;
               r_idx   <= '0;
               r_ready <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst && (r_state == S_CLEAR)) begin
         if (int'(r_idx) < NL) begin
            r_lht[r_idx[LBITS-1:0]] <= '0;
            r_cho[r_idx[LBITS-1:0]] <= c_cho_wl;
         end
         if (int'(r_idx) < NLP)
            r_lpht[r_idx[LHBITS-1:0]] <= c_ctr_wnt;
         if (int'(r_idx) < NG)
            r_gpht[r_idx[GHBITS-1:0]] <= c_ctr_wnt;
      end else if (!i_rst && w_upd) begin
         r_lht[w_u_lidx]  <= w_u_lh_new;
         r_cho[w_u_lidx]  <= w_u_cho_new;
         r_lpht[w_u_lh]   <= w_u_lctr_new;
         r_gpht[w_u_gidx] <= w_u_gctr_new;
      end
   end

   logic w_unused_addr_bits;
   assign w_unused_addr_bits = ^{i_pred_addr[1:0], i_pred_addr[31:AMAX+2],
                                 i_update_addr[1:0], i_update_addr[31:AMAX+2]};

   assign o_ready      = r_ready;
   assign o_pred_valid = r_pred_valid;
   assign o_pred_taken = r_pred_taken;
   assign o_pred_ghist = r_pred_ghist;

endmodule

`default_nettype wire
